image_plotter: RTL and testbench
================================

// Module: image_plotter
// PURPOSE
//  Downstream consumer of the master memory-address counter in the ImageSpit path.
//  - Drives the counter's enable and clear; takes its address stream plus the image ROM read data.
//  - Emits one VGA-adapter write (x, y, colour, plot) per image pixel, raster order.
//  - Converts the linear address to screen coordinates without a divider.
//  - Stops the counter at end of frame so it never wraps.
// PARAMETERS
//  IMG_W     240  image width in pixels
//  IMG_H     240  image height in pixels; IMG_W*IMG_H < 2**ADDR_W
//  X_OFFSET  40   screen x of image column 0
//  Y_OFFSET  0    screen y of image row 0
//  ADDR_W    16   address width, matches counter output
//  COLOUR_W  3    colour width, matches ROM data and VGA adapter
// PORTS
//  clk              in   1         system clock, rising edge
//  resetn           in   1         asynchronous active-low reset
//  start            in   1         begin one frame; sampled only in IDLE
//  mem_address      in   ADDR_W    current counter value (also the ROM read address)
//  mem_data         in   COLOUR_W  ROM data; valid 1 cycle after the address is presented
//  counter_enable   out  1         enable to the address counter
//  counter_clear_n  out  1         active-low synchronous clear to the address counter
//  x                out  9         screen x
//  y                out  8         screen y
//  colour           out  COLOUR_W  pixel colour
//  plot             out  1         one-cycle VGA write strobe
//  busy             out  1         high in CLEAR, RUN and DRAIN
//  done             out  1         one-cycle pulse at end of frame
//  sync_err         out  1         sticky: address did not match expected pixel index
// BEHAVIOUR
//  Reset (async, any state):
//  - state=IDLE; counter_enable=0, counter_clear_n=1.
//  - x=0, y=0, colour=0, plot=0, busy=0, done=0, sync_err=0.
//  - Pipeline valid bits cleared; col/row counters = 0.
//  FSM (all outputs registered):
//  - IDLE : start=1 -> CLEAR; sync_err cleared on this transition.
//  - CLEAR: counter_clear_n=0 for exactly 1 cycle -> RUN. Counter reads 0 on the first RUN cycle.
//  - RUN  : counter_enable=1 every cycle. The cycle mem_address==IMG_W*IMG_H-1 is presented -> DRAIN.
//           Counter then parks at IMG_W*IMG_H; that value is never plotted.
//  - DRAIN: counter_enable=0; wait until the last pixel's plot has issued (2 cycles) -> DONE.
//  - DONE : done=1 for 1 cycle -> IDLE.
//  Pipeline:
//  - Stage 1 (RUN only): register mem_address into a_d1 with valid v1.
//  - Stage 2 (v1=1):
//    - x <= X_OFFSET+col; y <= Y_OFFSET+row; colour <= mem_data; plot <= 1.
//    - Otherwise plot <= 0; x/y/colour hold their values.
//  - Latency: address presented in cycle k -> plot visible in cycle k+2.
//  Coordinates:
//  - col/row reset to 0 in CLEAR.
//  - Per stage-2 pixel, col increments; at col==IMG_W-1, col<=0 and row increments.
//  - x/y arithmetic zero-extends to 9/8 bits; no clipping.
//  Check:
//  - Independent pixel index idx, cleared in CLEAR, increments per plot.
//  - If a_d1 != idx while v1=1, sync_err sets; it holds until the next start.
//  - Plotting continues regardless.
//  Boundaries:
//  - start while not IDLE is ignored.
//  - start held high through DONE -> next frame begins 1 cycle after return to IDLE.
//  - Exactly IMG_W*IMG_H plots per frame. counter_enable is high for exactly IMG_W*IMG_H cycles.
// TESTING
//  T1 reset; start pulse at cycle 0; counter+ROM models (data=addr[2:0]):
//     -> counter_clear_n=0 at cycle 1; first plot at cycle 4 with (40,0).
//     -> addr 239 plots (279,0); addr 240 plots (40,1); last plot (279,239).
//     -> 57600 plots total; done 1 cycle after last plot; counter holds 57600.
//  T2 count counter_enable cycles over T1 -> exactly 57600; no plot with colour from addr 57600.
//  T3 start pulses at pixels 10 and 30000 mid-frame -> ignored; frame identical to T1.
//  T4 resetn low at pixel 1000 -> all outputs 0 same cycle, no further plot.
//     -> new start yields a full correct frame.
//  T5 bench model skips address 500->502 -> sync_err=1 from that plot onward; cleared by next start.
//  T6 IMG_W=4, IMG_H=3, X_OFFSET=0 -> 12 plots (0,0)..(3,0),(0,1)..(3,2); done after the 12th.

Source files
------------

// File: rtl/image_plotter.sv
// Image plotter: drives the master address counter through one frame and
// turns its linear address stream plus ROM data into raster-order VGA writes.
// Screen coordinates come from running column/row counters rather than a
// divider. An independent pixel index cross-checks the counter's addresses.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start
// S_CLEAR | counter held in synchronous clear for one cycle
// S_RUN   | counter enabled, addresses enter the pixel pipeline
// S_DRAIN | counter stopped, last pixel still moving through the pipeline
// S_DONE  | one-cycle end-of-frame pulse
module image_plotter #(
  parameter int IMG_W    = 240,
  parameter int IMG_H    = 240,
  parameter int X_OFFSET = 40,
  parameter int Y_OFFSET = 0,
  parameter int ADDR_W   = 16,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [ADDR_W-1:0]   mem_address,
  input  logic [COLOUR_W-1:0] mem_data,
  output logic                counter_enable,
  output logic                counter_clear_n,
  output logic [8:0]          x,
  output logic [7:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done,
  output logic                sync_err
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [8:0]        COL_LAST  = 9'(IMG_W - 1);

  state_t state_q, state_d;

  logic                counter_enable_q, counter_enable_d;
  logic                counter_clear_n_q, counter_clear_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ADDR_W-1:0]   a_d1_q;
  logic                v1_q;

  logic [8:0]          col_q, col_d;
  logic [7:0]          row_q, row_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [8:0]          x_q, x_d;
  logic [7:0]          y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;
  logic                sync_err_q, sync_err_d;

  // Next state and registered control outputs (decoded from the next state
  // so each output is aligned with the state it belongs to).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN:   if (mem_address == LAST_ADDR) state_d = S_DRAIN;
      S_DRAIN: if (!v1_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    counter_enable_d  = (state_d == S_RUN);
    counter_clear_n_d = (state_d != S_CLEAR);
    busy_d            = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d            = (state_d == S_DONE);
  end

  // State and control output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q           <= S_IDLE;
      counter_enable_q  <= 1'b0;
      counter_clear_n_q <= 1'b1;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      counter_enable_q  <= counter_enable_d;
      counter_clear_n_q <= counter_clear_n_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
    end
  end

  // Stage 1: capture the address only while the counter is running, so the
  // parked end-of-frame value never enters the pipeline.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_d1_q <= '0;
      v1_q   <= 1'b0;
    end else begin
      v1_q <= (state_q == S_RUN);
      if (state_q == S_RUN) a_d1_q <= mem_address;
    end
  end

  // Stage 2: coordinate generation, pixel output and address cross-check.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    idx_d      = idx_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    plot_d     = 1'b0;
    sync_err_d = sync_err_q;
    if (state_q == S_IDLE && start) sync_err_d = 1'b0;
    if (state_q == S_CLEAR) begin
      col_d = '0;
      row_d = '0;
      idx_d = '0;
    end
    if (v1_q) begin
      x_d      = 9'(X_OFFSET) + col_q;
      y_d      = 8'(Y_OFFSET) + row_q;
      colour_d = mem_data;
      plot_d   = 1'b1;
      idx_d    = idx_q + ADDR_W'(1);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 8'd1;
      end else begin
        col_d = col_q + 9'd1;
      end
      if (a_d1_q != idx_q) sync_err_d = 1'b1;
    end
  end

  // Stage 2 registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q      <= '0;
      row_q      <= '0;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign counter_enable  = counter_enable_q;
  assign counter_clear_n = counter_clear_n_q;
  assign x               = x_q;
  assign y               = y_q;
  assign colour          = colour_q;
  assign plot            = plot_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign sync_err        = sync_err_q;

endmodule

// File: tb/tb_image_plotter.sv
// Directed bench for image_plotter. Three instances share clock and reset:
// 0 = full 240x240 frame, 1 = 32x40 frame (reset / sync-error cases),
// 2 = 4x3 frame. Each has its own address counter and ROM model
// (ROM data = address[2:0], one cycle after the address).
module tb_image_plotter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        st    [3];
  logic [15:0] cnt   [3];
  logic [2:0]  rom   [3];
  logic        pen   [3];
  logic        pclr  [3];
  logic [8:0]  px    [3];
  logic [7:0]  py    [3];
  logic [2:0]  pc    [3];
  logic        pplot [3];
  logic        pbusy [3];
  logic        pdone [3];
  logic        perr  [3];
  logic        skip_b;

  int n_tests = 0;
  int n_fail  = 0;

  int n_plot, n_en, bad_pix, bad_sync, first_cyc, last_cyc, done_cyc, timed_out;
  int fx, fy, ax, ay, bx, by, lx, ly, lc;

  always #5 clk = ~clk;

  image_plotter u_a (
    .clk(clk), .resetn(resetn), .start(st[0]), .mem_address(cnt[0]), .mem_data(rom[0]),
    .counter_enable(pen[0]), .counter_clear_n(pclr[0]), .x(px[0]), .y(py[0]), .colour(pc[0]),
    .plot(pplot[0]), .busy(pbusy[0]), .done(pdone[0]), .sync_err(perr[0])
  );

  image_plotter #(.IMG_W(32), .IMG_H(40), .X_OFFSET(40), .Y_OFFSET(5)) u_b (
    .clk(clk), .resetn(resetn), .start(st[1]), .mem_address(cnt[1]), .mem_data(rom[1]),
    .counter_enable(pen[1]), .counter_clear_n(pclr[1]), .x(px[1]), .y(py[1]), .colour(pc[1]),
    .plot(pplot[1]), .busy(pbusy[1]), .done(pdone[1]), .sync_err(perr[1])
  );

  image_plotter #(.IMG_W(4), .IMG_H(3), .X_OFFSET(0)) u_c (
    .clk(clk), .resetn(resetn), .start(st[2]), .mem_address(cnt[2]), .mem_data(rom[2]),
    .counter_enable(pen[2]), .counter_clear_n(pclr[2]), .x(px[2]), .y(py[2]), .colour(pc[2]),
    .plot(pplot[2]), .busy(pbusy[2]), .done(pdone[2]), .sync_err(perr[2])
  );

  // Address counter and ROM models; instance 1 can skip address 501.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!resetn) begin
        cnt[k] <= 16'd0;
        rom[k] <= 3'd0;
      end else begin
        if (!pclr[k]) cnt[k] <= 16'd0;
        else if (pen[k]) cnt[k] <= (k == 1 && skip_b && cnt[k] == 16'd500) ? 16'd502 : cnt[k] + 16'd1;
        rom[k] <= cnt[k][2:0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called one sample after the start edge (cycle 1). Walks the frame cycle
  // by cycle, comparing every plot with the raster model, until done,
  // abort_at plots, or the cycle budget runs out.
  task automatic run_frame(input int s, input int w, input int h, input int xo, input int yo,
                           input bit skip, input int inj1, input int inj2, input int abort_at);
    int cyc, i, ea, tot;
    bit inj_now;
    tot = w * h - (skip ? 1 : 0);
    n_plot = 0; n_en = 0; bad_pix = 0; bad_sync = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1; timed_out = 1;
    fx = -1; fy = -1; ax = -1; ay = -1; bx = -1; by = -1; lx = -1; ly = -1; lc = -1;
    cyc = 1;
    inj_now = 1'b0;
    for (int c = 0; c < tot + 40; c++) begin
      if (pen[s]) n_en++;
      if (pplot[s]) begin
        i  = n_plot;
        ea = (skip && i >= 501) ? i + 1 : i;
        if (px[s] !== 9'(xo + i % w) || py[s] !== 8'(yo + i / w) || pc[s] !== 3'(ea % 8)) bad_pix++;
        if (perr[s] !== (skip && i >= 501)) bad_sync++;
        if (i == 0)     begin first_cyc = cyc; fx = int'(px[s]); fy = int'(py[s]); end
        if (i == w - 1) begin ax = int'(px[s]); ay = int'(py[s]); end
        if (i == w)     begin bx = int'(px[s]); by = int'(py[s]); end
        lx = int'(px[s]); ly = int'(py[s]); lc = int'(pc[s]); last_cyc = cyc;
        n_plot++;
      end
      if (pdone[s]) begin done_cyc = cyc; timed_out = 0; break; end
      if (n_plot == abort_at) begin timed_out = 0; break; end
      if (inj_now) begin st[s] = 1'b0; inj_now = 1'b0; end
      if (pplot[s] && (n_plot == inj1 || n_plot == inj2)) begin st[s] = 1'b1; inj_now = 1'b1; end
      @(posedge clk); #1;
      cyc++;
    end
    if (inj_now) st[s] = 1'b0;
  endtask

  task automatic kick(input int s);
    st[s] = 1'b1;
    @(posedge clk); #1;
    st[s] = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    skip_b = 1'b0;
    for (int k = 0; k < 3; k++) st[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en",     pen[0],   0);
    chk("rst_clr_n",  pclr[0],  1);
    chk("rst_x",      px[0],    0);
    chk("rst_y",      py[0],    0);
    chk("rst_colour", pc[0],    0);
    chk("rst_plot",   pplot[0], 0);
    chk("rst_busy",   pbusy[0], 0);
    chk("rst_done",   pdone[0], 0);
    chk("rst_serr",   perr[0],  0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Full 240x240 frame with stray starts after plots 10 and 30000.
    kick(0);
    chk("a_clear_n_c1", pclr[0],  0);
    chk("a_busy_c1",    pbusy[0], 1);
    run_frame(0, 240, 240, 40, 0, 1'b0, 10, 30000, -1);
    chk("a_timeout",    timed_out, 0);
    chk("a_plots",      n_plot,    57600);
    chk("a_bad_pix",    bad_pix,   0);
    chk("a_bad_sync",   bad_sync,  0);
    chk("a_enables",    n_en,      57600);
    chk("a_first_cyc",  first_cyc, 4);
    chk("a_first_x",    fx, 40);
    chk("a_first_y",    fy, 0);
    chk("a_p239_x",     ax, 279);
    chk("a_p239_y",     ay, 0);
    chk("a_p240_x",     bx, 40);
    chk("a_p240_y",     by, 1);
    chk("a_last_x",     lx, 279);
    chk("a_last_y",     ly, 239);
    chk("a_last_col",   lc, 7);
    chk("a_done_cyc",   done_cyc, last_cyc + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("a_cnt_park",   cnt[0],   57600);
    chk("a_busy_after", pbusy[0], 0);
    chk("a_plot_after", pplot[0], 0);

    // Asynchronous reset at pixel 1000, then a clean frame.
    kick(1);
    run_frame(1, 32, 40, 40, 5, 1'b0, -1, -1, 1000);
    chk("b_pre_abort",  n_plot,   1000);
    chk("b_pre_bad",    bad_pix,  0);
    resetn = 1'b0;
    #1;
    chk("b_rst_plot",   pplot[1], 0);
    chk("b_rst_x",      px[1],    0);
    chk("b_rst_y",      py[1],    0);
    chk("b_rst_colour", pc[1],    0);
    chk("b_rst_busy",   pbusy[1], 0);
    chk("b_rst_en",     pen[1],   0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("b_noplot",     pplot[1], 0);
    chk("b_idle_busy",  pbusy[1], 0);
    kick(1);
    run_frame(1, 32, 40, 40, 5, 1'b0, -1, -1, -1);
    chk("b_timeout",    timed_out, 0);
    chk("b_plots",      n_plot,    1280);
    chk("b_bad_pix",    bad_pix,   0);
    chk("b_enables",    n_en,      1280);
    chk("b_first_cyc",  first_cyc, 4);
    chk("b_last_x",     lx, 71);
    chk("b_last_y",     ly, 44);
    chk("b_done_cyc",   done_cyc, last_cyc + 1);

    // Counter skips 500 -> 502: sync_err from that plot on, cleared by next start.
    skip_b = 1'b1;
    @(posedge clk); #1;
    kick(1);
    run_frame(1, 32, 40, 40, 5, 1'b1, -1, -1, -1);
    chk("s_timeout",    timed_out, 0);
    chk("s_plots",      n_plot,    1279);
    chk("s_bad_sync",   bad_sync,  0);
    chk("s_bad_pix",    bad_pix,   0);
    @(posedge clk); #1;
    chk("s_sticky",     perr[1],   1);
    skip_b = 1'b0;
    kick(1);
    chk("s_cleared",    perr[1],   0);
    run_frame(1, 32, 40, 40, 5, 1'b0, -1, -1, -1);
    chk("s2_plots",     n_plot,    1280);
    chk("s2_bad_sync",  bad_sync,  0);

    // 4x3 frame with start held high through DONE, then back-to-back frame.
    st[2] = 1'b1;
    @(posedge clk); #1;
    chk("c_clear_n_c1", pclr[2], 0);
    run_frame(2, 4, 3, 0, 0, 1'b0, -1, -1, -1);
    chk("c_timeout",    timed_out, 0);
    chk("c_plots",      n_plot,    12);
    chk("c_bad_pix",    bad_pix,   0);
    chk("c_enables",    n_en,      12);
    chk("c_first_cyc",  first_cyc, 4);
    chk("c_p3_x",       ax, 3);
    chk("c_p3_y",       ay, 0);
    chk("c_p4_x",       bx, 0);
    chk("c_p4_y",       by, 1);
    chk("c_last_x",     lx, 3);
    chk("c_last_y",     ly, 2);
    chk("c_done_cyc",   done_cyc, last_cyc + 1);
    @(posedge clk); #1;
    chk("c_idle_busy",  pbusy[2], 0);
    chk("c_idle_clr",   pclr[2],  1);
    @(posedge clk); #1;
    chk("c_rearm_clr",  pclr[2],  0);
    chk("c_rearm_busy", pbusy[2], 1);
    st[2] = 1'b0;
    run_frame(2, 4, 3, 0, 0, 1'b0, -1, -1, -1);
    chk("c2_plots",     n_plot,   12);
    chk("c2_bad_pix",   bad_pix,  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
